// File: rtl/decision_making.sv
// Per-frame packet filter: parses Ethernet/IPv4/TCP/UDP header bytes from a passive
// AXI-stream tap and emits one registered pass/drop verdict per frame plus a drop count.
module decision_making #(
    parameter int          DATA_WIDTH    = 256,
    parameter int          KEEP_WIDTH    = DATA_WIDTH/8,
    parameter logic [31:0] BLOCKED_IP    = 32'h00000000,
    parameter logic [15:0] BLOCKED_PORT  = 16'h0000,
    parameter bit          DROP_NON_IPV4 = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [KEEP_WIDTH-1:0] data_keep,
    input  logic                  data_valid,
    input  logic                  data_last,
    output logic [31:0]           data_out
);

    localparam int BCW = $clog2(38/KEEP_WIDTH + 2);
    localparam int NH  = 10;
    // Frame byte offsets of every header byte the filter looks at.
    localparam int HDR_IDX [NH] = '{12, 13, 14, 23, 30, 31, 32, 33, 36, 37};

    typedef enum logic [1:0] {S_START, S_PARSE, S_SKIP} state_t;

    state_t          state, state_next;
    logic [BCW-1:0]  bcnt, bcnt_cur;
    logic [NH-1:0]   seen, seen_cur, hit;
    logic [7:0]      hdr     [NH];
    logic [7:0]      hdr_cur [NH];
    logic            active, decide, reached, drop;
    logic [2:0]      reason;
    logic            eth_known, l4_known, ip_known, port_known, ihl5;
    logic            is_ipv4, is_tcp, is_udp;
    logic [15:0]     ethertype, dest_port;
    logic [31:0]     dest_ip;
    logic            data_unused;

    // Only a handful of byte lanes are ever inspected.
    assign data_unused = ^{data, data_keep};

    // A fresh frame always starts counting from beat 0, regardless of stale state.
    assign bcnt_cur = (state == S_START) ? '0 : bcnt;
    assign active   = data_valid && (state != S_SKIP);

    genvar g;
    generate
        for (g = 0; g < NH; g++) begin : g_hdr
            assign hit[g]      = active && (bcnt_cur == BCW'(HDR_IDX[g] / KEEP_WIDTH))
                                 && data_keep[HDR_IDX[g] % KEEP_WIDTH];
            assign seen_cur[g] = hit[g] | ((state == S_PARSE) & seen[g]);
            assign hdr_cur[g]  = hit[g] ? data[(HDR_IDX[g] % KEEP_WIDTH)*8 +: 8] : hdr[g];
        end
    endgenerate

    assign eth_known  = seen_cur[0] & seen_cur[1];
    assign l4_known   = seen_cur[2] & seen_cur[3];
    assign ip_known   = &seen_cur[7:4];
    assign port_known = &seen_cur[9:8];
    assign ethertype  = {hdr_cur[0], hdr_cur[1]};
    assign dest_ip    = {hdr_cur[4], hdr_cur[5], hdr_cur[6], hdr_cur[7]};
    assign dest_port  = {hdr_cur[8], hdr_cur[9]};
    assign ihl5       = hdr_cur[2][3:0] == 4'd5;
    assign is_ipv4    = eth_known && (ethertype == 16'h0800);
    assign is_tcp     = is_ipv4 && l4_known && ihl5 && (hdr_cur[3] == 8'h06);
    assign is_udp     = is_ipv4 && l4_known && ihl5 && (hdr_cur[3] == 8'h11);

    assign reached = (eth_known && !is_ipv4)
                  || (is_ipv4 && l4_known && ip_known && !(is_tcp || is_udp))
                  || ((is_tcp || is_udp) && ip_known && port_known);
    assign decide  = active && (reached || data_last);

    always_comb begin
        drop   = 1'b0;
        reason = 3'd0;
        if (!reached) begin
            drop   = 1'b1;
            reason = 3'd4;
        end else if (!is_ipv4) begin
            drop   = DROP_NON_IPV4;
            reason = DROP_NON_IPV4 ? 3'd1 : 3'd0;
        end else if (BLOCKED_IP != 32'h0 && dest_ip == BLOCKED_IP) begin
            drop   = 1'b1;
            reason = 3'd2;
        end else if ((is_tcp || is_udp) && BLOCKED_PORT != 16'h0 && dest_port == BLOCKED_PORT) begin
            drop   = 1'b1;
            reason = 3'd3;
        end
    end

    always_comb begin
        state_next = state;
        if (data_valid) begin
            if (data_last)   state_next = S_START;
            else if (decide) state_next = S_SKIP;
            else             state_next = S_PARSE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_START;
            bcnt     <= '0;
            seen     <= '0;
            data_out <= '0;
            for (int i = 0; i < NH; i++) hdr[i] <= '0;
        end else begin
            state       <= state_next;
            data_out[0] <= decide;
            if (active) begin
                bcnt <= (bcnt_cur == '1) ? bcnt_cur : bcnt_cur + 1'b1;
                seen <= seen_cur;
                for (int i = 0; i < NH; i++) hdr[i] <= hdr_cur[i];
            end
            if (decide) begin
                data_out[7:1] <= {reason, is_udp, is_tcp, is_ipv4, drop};
                if (drop && data_out[31:16] != 16'hFFFF)
                    data_out[31:16] <= data_out[31:16] + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_decision_making.sv
// Scoreboard bench: two filter instances (256-bit with all rules on, 64-bit defaults);
// expected verdict words and strobe cycles are queued as frames are driven.
module tb_decision_making;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [255:0] da;
    logic [31:0]  ka, oa;
    logic         va, la;
    logic [63:0]  db;
    logic [7:0]   kb;
    logic [31:0]  ob;
    logic         vb, lb;

    decision_making #(.DATA_WIDTH(256), .BLOCKED_IP(32'hC0A80001), .BLOCKED_PORT(16'd80),
                      .DROP_NON_IPV4(1'b1)) u_a (
        .clk(clk), .rst(rst), .data(da), .data_keep(ka), .data_valid(va),
        .data_last(la), .data_out(oa));

    decision_making #(.DATA_WIDTH(64)) u_b (
        .clk(clk), .rst(rst), .data(db), .data_keep(kb), .data_valid(vb),
        .data_last(lb), .data_out(ob));

    typedef struct {
        logic [31:0] w;
        logic [31:0] m;
        int          c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] fr [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && oa[0]) begin
            if (qa.size() == 0) chk("extra_strobe_a", oa, 32'h0);
            else begin
                e = qa.pop_front();
                chk("verdict_a", oa & e.m, e.w);
                chk("cycle_a", cyc, e.c);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ob[0]) begin
            if (qb.size() == 0) chk("extra_strobe_b", ob, 32'h0);
            else begin
                e = qb.pop_front();
                chk("verdict_b", ob & e.m, e.w);
                chk("cycle_b", cyc, e.c);
            end
        end
    end

    task automatic build(input logic [15:0] et, input logic [3:0] ihl, input logic [7:0] proto,
                         input logic [31:0] dip, input logic [15:0] dport);
        for (int i = 0; i < 64; i++) fr[i] = 8'(i*7 + 3);
        fr[12] = et[15:8];   fr[13] = et[7:0];
        fr[14] = {4'h4, ihl}; fr[23] = proto;
        fr[30] = dip[31:24]; fr[31] = dip[23:16]; fr[32] = dip[15:8]; fr[33] = dip[7:0];
        fr[36] = dport[15:8]; fr[37] = dport[7:0];
    endtask

    // Drives beats [0, stop) of an len-byte frame; beat 'dec' is expected to carry the verdict.
    task automatic send(input bit sel, input int len, input int stop, input int dec,
                        input logic [31:0] w, input logic [31:0] m, input int gap);
        int kw, nb, idx;
        logic [255:0] d;
        logic [31:0]  k;
        exp_t e;
        kw = sel ? 8 : 32;
        nb = (len + kw - 1) / kw;
        for (int b = 0; b < nb && b < stop; b++) begin
            for (int g = 0; g < gap; g++) begin
                va = 1'b0; vb = 1'b0;
                da = {8{$urandom}}; db = {2{$urandom}};
                la = 1'($urandom); lb = 1'($urandom);
                ka = $urandom; kb = 8'($urandom);
                @(posedge clk); #1;
            end
            d = '0; k = '0;
            for (int l = 0; l < kw; l++) begin
                idx = b*kw + l;
                if (idx < len) begin
                    d[l*8 +: 8] = fr[idx];
                    k[l] = 1'b1;
                end else d[l*8 +: 8] = 8'($urandom);
            end
            if (sel) begin
                db = d[63:0]; kb = k[7:0]; vb = 1'b1; lb = (b == nb-1);
            end else begin
                da = d; ka = k; va = 1'b1; la = (b == nb-1);
            end
            if (b == dec) begin
                e.w = w; e.m = m; e.c = cyc + 1;
                if (sel) qb.push_back(e); else qa.push_back(e);
            end
            @(posedge clk); #1;
        end
        va = 1'b0; la = 1'b0; vb = 1'b0; lb = 1'b0;
    endtask

    initial begin
        da = '0; ka = '0; va = 1'b0; la = 1'b0;
        db = '0; kb = '0; vb = 1'b0; lb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", oa, 32'h0);
        chk("reset_b", ob, 32'h0);
        rst = 1'b0;

        // 256-bit instance, back-to-back frames
        build(16'h0800, 4'd5, 8'h11, 32'h0A000001, 16'd53);
        send(0, 64, 99, 1, 32'h0000_0015, '1, 0);
        build(16'h0800, 4'd5, 8'h06, 32'hC0A80001, 16'd1234);
        for (int r = 0; r < 4; r++)
            send(0, 64, 99, 1, {16'(r+1), 16'h004F}, '1, r % 2);
        build(16'h0800, 4'd5, 8'h06, 32'h0A000002, 16'd80);
        send(0, 64, 99, 1, 32'h0005_006F, '1, 0);
        build(16'h0800, 4'd6, 8'h06, 32'h0A000002, 16'd80);
        send(0, 64, 99, 1, 32'h0005_0005, '1, 0);
        build(16'h86DD, 4'd5, 8'h06, 32'h0A000002, 16'd80);
        send(0, 32, 99, 0, 32'h0006_0023, '1, 0);
        build(16'h0800, 4'd5, 8'h06, 32'h0A000003, 16'd80);
        send(0, 34, 99, 1, 32'h0007_0083, 32'hFFFF_FFE3, 0);
        build(16'h0800, 4'd5, 8'h11, 32'h0A000004, 16'd53);
        send(0, 38, 99, 1, 32'h0007_0015, '1, 0);
        repeat (3) @(posedge clk);
        #1;

        // 64-bit instance with idle gaps
        build(16'h0800, 4'd5, 8'h11, 32'h0A000001, 16'd53);
        send(1, 48, 99, 4, 32'h0000_0015, '1, 2);
        build(16'h86DD, 4'd5, 8'h11, 32'h0A000001, 16'd53);
        send(1, 16, 99, 1, 32'h0000_0001, '1, 1);
        build(16'h0800, 4'd5, 8'h06, 32'h0A000001, 16'd53);
        send(1, 20, 99, 2, 32'h0001_0083, 32'hFFFF_FFE3, 1);
        build(16'h0800, 4'd5, 8'h11, 32'hC0A80001, 16'd80);
        send(1, 48, 2, -1, 32'h0, 32'h0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_b", ob, 32'h0);
        rst = 1'b0;
        build(16'h0800, 4'd5, 8'h11, 32'h0A000005, 16'd53);
        send(1, 48, 99, 4, 32'h0000_0015, '1, 1);
        repeat (4) @(posedge clk);
        #1;

        chk("pending_a", qa.size(), 32'd0);
        chk("pending_b", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
